mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 6, meaning the word array holds 2^DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, meaning wait states inserted before each response (legal 0..15).
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Req  input  1  initiator requests a memory access.
REQ-006 MemWrite  input  1  1 = write access, 0 = read access; qualified by Req.
REQ-007 Addr  input  32  byte address of the access.
REQ-008 WData  input  32  write data; qualified by Req and MemWrite.
REQ-009 Ready  output  1  one-cycle response strobe: access complete.
REQ-010 RData  output  32  registered read data.
REQ-011 Err  output  1  access was misaligned; valid while Ready=1.
REQ-012 Busy  output  1  1 whenever state is not IDLE.
REQ-013 Stat  output  2  current FSM state encoding for debug.

Function
REQ-014 The FSM SHALL have states IDLE (Stat=00), WAIT (01) and RESP (10); encoding 11 SHALL return to IDLE on the next edge.
REQ-015 In IDLE with Req=1, the block SHALL latch Addr, WData and MemWrite on the clock edge.
- Next state is WAIT with the counter loaded to WAIT_CYCLES-1 when WAIT_CYCLES>0.
- Next state is RESP when WAIT_CYCLES=0.
REQ-016 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL move to RESP on the edge where the counter equals 0.
REQ-017 The access SHALL take effect on the edge entering RESP.
- Write: the word at index Addr[DEPTH_LOG2+1:2] is written.
- Read: RData is loaded from that index.
REQ-018 In RESP, Ready SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-019 Latency: Req sampled in cycle 0 SHALL give Ready=1 in cycle WAIT_CYCLES+1.
REQ-020 Req SHALL be ignored in WAIT and RESP, with no queuing.
- The next request is accepted no earlier than cycle WAIT_CYCLES+2.
- Peak throughput is one access per WAIT_CYCLES+2 cycles.
REQ-021 Changes on Addr, WData or MemWrite after acceptance SHALL have no effect on the pending access.
REQ-022 Misaligned access (latched Addr[1:0] != 00):
- No memory write occurs.
- RData is loaded with 0.
- Err=1 together with Ready, with unchanged latency.
REQ-023 Err SHALL be 0 whenever Ready=0 and for aligned accesses.
REQ-024 Address bits above DEPTH_LOG2+1 SHALL be ignored, so addresses alias (wrap) modulo 2^(DEPTH_LOG2+2) bytes.
REQ-025 RData SHALL change only on a read response or a misaligned response; it SHALL hold its value across write responses and idle cycles.
REQ-026 A read after a write to the same word SHALL return the newly written data.
REQ-027 Busy SHALL equal (Stat != 00).

Reset
REQ-028 With Reset=1 at a rising edge, the block SHALL set state=IDLE, counter=0, Ready=0, Err=0, RData=0 and Busy=0.
REQ-029 Reset SHALL take priority over Req; a request presented in the same cycle as Reset SHALL NOT be accepted.
REQ-030 Reset asserted during WAIT SHALL abort the pending access, and an aborted write SHALL NOT modify memory.
REQ-031 Memory array contents SHALL NOT be cleared by Reset; power-up contents are undefined unless preloaded by the bench.

Verification (WAIT_CYCLES=2, DEPTH_LOG2=6)
REQ-032 Write then read: write Addr=0x10, WData=0xDEADBEEF; then read Addr=0x10 -> both Ready pulses occur 3 cycles after acceptance, and RData=0xDEADBEEF with Err=0.
REQ-033 Back-to-back: hold Req=1 continuously with reads of 0x0, 0x4 and 0x8 -> accepted at cycles 0, 4 and 8, with Ready at cycles 3, 7 and 11.
REQ-034 Misaligned: write Addr=0x22, WData=0x1234; then read 0x20 -> the first Ready comes with Err=1 and RData=0, and the word at 0x20 is unchanged.
REQ-035 Aliasing: write Addr=0x104 with 0xA5A5A5A5; then read Addr=0x4 -> RData=0xA5A5A5A5.
REQ-036 Reset mid-access: write Addr=0x8 with 0x55; assert Reset in the first WAIT cycle -> Ready never asserts, Stat=00 and RData=0; a subsequent read of 0x8 returns the prior contents.
REQ-037 WAIT_CYCLES=0 build: read request in cycle 0 -> Ready=1 in cycle 1, and the state never reports WAIT.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory responder with programmable wait states.
// One access in flight; misaligned accesses complete with Err and no write.
module mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Ready,
  output logic [31:0] RData,
  output logic        Err,
  output logic        Busy,
  output logic [1:0]  Stat
);

  localparam int AW    = DEPTH_LOG2 + 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            we_q;
  logic [31:0]     mem [DEPTH];

  logic            go;
  logic [AW-1:0]   a_addr;
  logic [31:0]     a_wdata;
  logic            a_we;
  logic            aligned;
  logic [DEPTH_LOG2-1:0] idx;

  logic unused_addr;
  assign unused_addr = ^Addr[31:AW];

  // With zero wait states the access fires on the accepting edge,
  // so it must use the live inputs rather than the latched copy.
  always_comb begin
    go      = 1'b0;
    a_addr  = addr_q;
    a_wdata = wdata_q;
    a_we    = we_q;
    if (WAIT_CYCLES == 0 && state == S_IDLE && Req) begin
      go      = 1'b1;
      a_addr  = Addr[AW-1:0];
      a_wdata = WData;
      a_we    = MemWrite;
    end else if (state == S_WAIT && cnt == 4'd0) begin
      go = 1'b1;
    end
  end

  assign aligned = (a_addr[1:0] == 2'b00);
  assign idx     = a_addr[AW-1:2];

  always_ff @(posedge CLK) begin
    if (!Reset && go && a_we && aligned)
      mem[idx] <= a_wdata;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      Ready <= 1'b0;
      Err   <= 1'b0;
      RData <= 32'd0;
    end else begin
      Ready <= 1'b0;
      Err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Req) begin
            addr_q  <= Addr[AW-1:0];
            wdata_q <= WData;
            we_q    <= MemWrite;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WLOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (go) begin
        Ready <= 1'b1;
        Err   <= !aligned;
        if (!aligned)  RData <= 32'd0;
        else if (!a_we) RData <= mem[idx];
      end
    end
  end

  assign Stat = state;
  assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: phase-count reference model plus directed
// literal checks, random traffic, and a zero-wait-state instance.
module tb_mem_responder;

  localparam int W = 2;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        Reset = 1'b1, Req = 1'b0, MemWrite = 1'b0;
  logic [31:0] Addr = '0, WData = '0;
  logic        Ready, Err, Busy;
  logic [31:0] RData;
  logic [1:0]  Stat;

  logic        Reset0 = 1'b1, Req0 = 1'b0, MemWrite0 = 1'b0;
  logic [31:0] Addr0 = '0, WData0 = '0;
  logic        Ready0, Err0, Busy0;
  logic [31:0] RData0;
  logic [1:0]  Stat0;

  mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(W)) dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .MemWrite(MemWrite),
    .Addr(Addr), .WData(WData), .Ready(Ready), .RData(RData),
    .Err(Err), .Busy(Busy), .Stat(Stat)
  );

  mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .Reset(Reset0), .Req(Req0), .MemWrite(MemWrite0),
    .Addr(Addr0), .WData(WData0), .Ready(Ready0), .RData(RData0),
    .Err(Err0), .Busy(Busy0), .Stat(Stat0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  // Reference model: k counts cycles since acceptance; the access
  // lands in cycle W+1 and the block is idle again in cycle W+2.
  int          cyc = 0;
  bit          act = 1'b0;
  int          k = 0;
  logic        p_we;
  logic [31:0] p_a, p_d;
  logic        e_ready = 1'b0, e_err = 1'b0;
  logic [31:0] e_rdata = '0;
  logic [1:0]  e_stat = '0;
  logic [31:0] mm [64];
  logic [31:0] initv [64];
  bit          chk_en = 1'b0;
  bit          saw_wait0 = 1'b0;

  initial forever begin
    @(posedge CLK);
    if (Reset) begin
      act = 1'b0;
      e_rdata = '0;
    end else if (act) begin
      if (k == W + 1) act = 1'b0;
      else k++;
    end else if (Req) begin
      act = 1'b1;
      k = 1;
      p_we = MemWrite;
      p_a = Addr;
      p_d = WData;
    end
    if (!Reset && act && k == W + 1) begin
      if (p_a[1:0] != 2'b00) e_rdata = '0;
      else if (p_we) mm[p_a[7:2]] = p_d;
      else e_rdata = mm[p_a[7:2]];
    end
    e_ready = act && (k == W + 1);
    e_err   = e_ready && (p_a[1:0] != 2'b00);
    e_stat  = !act ? 2'b00 : ((k == W + 1) ? 2'b10 : 2'b01);
    cyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      chk("ready", Ready, e_ready);
      chk("err", Err, e_err);
      chk("rdata", RData, e_rdata);
      chk("stat", Stat, e_stat);
      chk("busy", Busy, e_stat != 2'b00);
    end
    if (Stat0 == 2'b01) saw_wait0 = 1'b1;
  end

  task automatic access(input logic we, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output int lat);
    int t0;
    lat = -1;
    rd = 'x;
    er = 1'bx;
    for (int i = 0; i < 20 && act; i++) @(negedge CLK);
    Req = 1'b1;
    MemWrite = we;
    Addr = a;
    WData = d;
    t0 = cyc;
    @(negedge CLK);
    Req = 1'b0;
    MemWrite = ~we;
    Addr = $urandom;
    WData = $urandom;
    for (int i = 0; i < 20; i++) begin
      if (Ready) begin
        lat = cyc - t0;
        rd = RData;
        er = Err;
        break;
      end
      @(negedge CLK);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          c0, n;
  int          rq[$];
  bit          seen;
  logic [31:0] ra;

  initial begin
    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    chk("rst_ready", Ready, 0);
    chk("rst_rdata", RData, 0);
    chk("rst_stat", Stat, 0);
    chk("rst_busy", Busy, 0);
    // request during reset must be dropped
    Req = 1'b1;
    @(negedge CLK);
    chk("rst_prio_stat", Stat, 0);
    Req = 1'b0;
    Reset = 1'b0;
    Reset0 = 1'b0;

    for (int i = 0; i < 64; i++) begin
      initv[i] = $urandom;
      access(1'b1, 32'(i * 4), initv[i], rd, er, lat);
    end

    access(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("wr_lat", lat, 3);
    chk("wr_err", er, 0);
    access(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("rd_lat", lat, 3);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_err", er, 0);

    for (int i = 0; i < 20 && act; i++) @(negedge CLK);
    Req = 1'b1;
    MemWrite = 1'b0;
    Addr = 32'h0;
    c0 = cyc;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      if (Ready) begin
        rq.push_back(cyc - c0);
        n++;
        Addr = 32'(n * 4);
      end
    end
    Req = 1'b0;
    chk("b2b_count", rq.size(), 3);
    if (rq.size() == 3) begin
      chk("b2b_r0", rq[0], 3);
      chk("b2b_r1", rq[1], 7);
      chk("b2b_r2", rq[2], 11);
    end

    access(1'b1, 32'h22, 32'h1234, rd, er, lat);
    chk("mis_err", er, 1);
    chk("mis_rdata", rd, 0);
    chk("mis_lat", lat, 3);
    access(1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("mis_keep", rd, initv[8]);
    chk("mis_rd_err", er, 0);

    access(1'b1, 32'h104, 32'hA5A5A5A5, rd, er, lat);
    access(1'b0, 32'h4, 32'h0, rd, er, lat);
    chk("alias", rd, 32'hA5A5A5A5);

    for (int i = 0; i < 20 && act; i++) @(negedge CLK);
    Req = 1'b1;
    MemWrite = 1'b1;
    Addr = 32'h8;
    WData = 32'h55;
    @(negedge CLK);
    Req = 1'b0;
    chk("abort_wait", Stat, 1);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    chk("abort_stat", Stat, 0);
    chk("abort_rdata", RData, 0);
    chk("abort_busy", Busy, 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (Ready) seen = 1'b1;
    end
    chk("abort_noready", seen, 0);
    access(1'b0, 32'h8, 32'h0, rd, er, lat);
    chk("abort_mem", rd, initv[2]);

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      ra[1:0] = ($urandom_range(0, 7) == 0) ?
                2'($urandom_range(1, 3)) : 2'b00;
      Reset = ($urandom_range(0, 49) == 0);
      Req = 1'($urandom_range(0, 1));
      MemWrite = 1'($urandom_range(0, 1));
      Addr = ra;
      WData = $urandom;
      @(negedge CLK);
    end
    Reset = 1'b0;
    Req = 1'b0;
    repeat (6) @(negedge CLK);

    Req0 = 1'b1;
    MemWrite0 = 1'b1;
    Addr0 = 32'h4;
    WData0 = 32'h77;
    @(negedge CLK);
    Req0 = 1'b0;
    chk("w0_ready", Ready0, 1);
    chk("w0_stat", Stat0, 2);
    @(negedge CLK);
    chk("w0_idle_ready", Ready0, 0);
    chk("w0_idle_stat", Stat0, 0);
    Req0 = 1'b1;
    MemWrite0 = 1'b0;
    @(negedge CLK);
    Req0 = 1'b0;
    chk("w0_rd_ready", Ready0, 1);
    chk("w0_rd_data", RData0, 32'h77);
    chk("w0_rd_err", Err0, 0);
    chk("w0_no_wait", saw_wait0, 0);

    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
